// File: rtl/conv_control.sv
// conv_control: 4x4 FP16 ifmap convolved with a 3x3 FP16 kernel into a 2x2 output, one MAC per cycle.
// Optional ReLU at the result register: define CONV_CONTROL_RELU_EN.
module conv_control (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [15:0]  conv_num,
    input  logic [143:0] weight_3x3,
    output logic [15:0]  result,
    output logic         done,
    output logic         dout_valid
);
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

    state_t      state_q;
    logic [15:0] ifmap_q  [16];
    logic [15:0] weight_q [9];
    logic [15:0] acc_q;
    logic [15:0] result_q;
    logic [3:0]  load_idx_q;
    logic [3:0]  k_q;
    logic [2:0]  win_q;
    logic        out_pending_q;
    logic        dout_valid_q;
    logic        done_q;

    // Subnormals become signed zero, Inf/NaN become max finite.
    function automatic logic [15:0] fp_canon(input logic [15:0] x);
        if (x[14:10] == 5'd0)  return {x[15], 15'd0};
        if (x[14:10] == 5'h1F) return {x[15], 15'h7BFF};
        return x;
    endfunction

    function automatic logic [15:0] fp_pack(input logic s, input int e, input logic [9:0] m);
        if (e >= 31) return {s, 15'h7BFF};
        if (e <= 0)  return {s, 15'd0};
        return {s, e[4:0], m};
    endfunction

    function automatic logic [15:0] fp_mul(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] a;
        logic [15:0] b;
        logic [21:0] p;
        logic [9:0]  m;
        int          e;
        a = fp_canon(a_in);
        b = fp_canon(b_in);
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return 16'h0000;
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15 + (p[21] ? 1 : 0);
        m = 10'(p >> (p[21] ? 11 : 10));
        return fp_pack(a[15] ^ b[15], e, m);
    endfunction

    // Operands are aligned in a wide field so the sum is exact before truncation.
    function automatic logic [15:0] fp_add(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] big;
        logic [15:0] sml;
        logic [44:0] mb;
        logic [44:0] ms;
        logic [44:0] sum;
        logic [9:0]  m;
        int          p;
        int          e;
        a = fp_canon(a_in);
        b = fp_canon(b_in);
        if (a[14:0] < b[14:0]) begin
            big = b;
            sml = a;
        end else begin
            big = a;
            sml = b;
        end
        if (big[14:0] == 15'd0) return 16'h0000;
        mb = 45'({1'b1, big[9:0]}) << 30;
        if (sml[14:0] == 15'd0) ms = '0;
        else ms = (45'({1'b1, sml[9:0]}) << 30) >> (big[14:10] - sml[14:10]);
        sum = (big[15] == sml[15]) ? mb + ms : mb - ms;
        if (sum == '0) return 16'h0000;
        p = 0;
        for (int i = 0; i < 45; i++) begin
            if (sum[i]) p = i;
        end
        e = int'(big[14:10]) + p - 40;
        m = 10'((sum << (44 - p)) >> 34);
        return fp_pack(big[15], e, m);
    endfunction

    // Window (r,c) tap k reads ifmap[(r + k/3)*4 + c + k%3].
    function automatic logic [3:0] tap_idx(input logic [1:0] win, input logic [3:0] k);
        logic [3:0] off;
        case (k)
            4'd0:    off = 4'd0;
            4'd1:    off = 4'd1;
            4'd2:    off = 4'd2;
            4'd3:    off = 4'd4;
            4'd4:    off = 4'd5;
            4'd5:    off = 4'd6;
            4'd6:    off = 4'd8;
            4'd7:    off = 4'd9;
            default: off = 4'd10;
        endcase
        return {1'b0, win[1], 1'b0, win[0]} + off;
    endfunction

    logic [15:0] mac_sum;
    logic [15:0] out_val;

    assign mac_sum = fp_add((k_q == 4'd0) ? 16'h0000 : acc_q,
                            fp_mul(ifmap_q[tap_idx(win_q[1:0], k_q)], weight_q[k_q]));

`ifdef CONV_CONTROL_RELU_EN
    assign out_val = acc_q[15] ? 16'h0000 : acc_q;
`else
    assign out_val = acc_q;
`endif

    // The finished accumulator is copied to result on the same edge that starts the next window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            // NOTE: ifmap and weight storage is reset explicitly so an aborted pass leaves no stale data.
            for (int i = 0; i < 16; i++) ifmap_q[i] <= '0;
            for (int i = 0; i < 9; i++)  weight_q[i] <= '0;
            acc_q         <= '0;
            result_q      <= '0;
            load_idx_q    <= '0;
            k_q           <= '0;
            win_q         <= '0;
            out_pending_q <= 1'b0;
            dout_valid_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ifmap_q[0] <= conv_num;
                        for (int i = 0; i < 9; i++) weight_q[i] <= weight_3x3[16*i +: 16];
                        load_idx_q <= 4'd1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    ifmap_q[load_idx_q] <= conv_num;
                    load_idx_q          <= load_idx_q + 4'd1;
                    if (load_idx_q == 4'd15) begin
                        k_q           <= '0;
                        win_q         <= '0;
                        out_pending_q <= 1'b0;
                        state_q       <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (out_pending_q) begin
                        result_q     <= out_val;
                        dout_valid_q <= 1'b1;
                    end
                    if (win_q != 3'd4) begin
                        acc_q         <= mac_sum;
                        out_pending_q <= (k_q == 4'd8);
                        if (k_q == 4'd8) begin
                            k_q   <= '0;
                            win_q <= win_q + 3'd1;
                        end else begin
                            k_q <= k_q + 4'd1;
                        end
                    end else begin
                        out_pending_q <= 1'b0;
                        if (!out_pending_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result     = result_q;
    assign done       = done_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_conv_control.sv
// Directed bench for conv_control: full passes with hand-computed results, reset abort, done hold.
module tb_conv_control;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  conv_num = '0;
    logic [143:0] weight_3x3 = '0;
    logic [15:0]  result;
    logic         done;
    logic         dout_valid;

    int checks = 0;
    int errors = 0;

    logic [15:0] img   [16];
    logic [15:0] wts   [9];
    logic [15:0] exp_r [4];
    logic [15:0] ramp  [16] = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200,
                                16'h4400, 16'h4500, 16'h4600, 16'h4700,
                                16'h4800, 16'h4880, 16'h4900, 16'h4980,
                                16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80};

    always #5 clk = ~clk;

    conv_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .conv_num   (conv_num),
        .weight_3x3 (weight_3x3),
        .result     (result),
        .done       (done),
        .dout_valid (dout_valid)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_all(input logic [15:0] iv, input logic [15:0] wv, input logic [15:0] rv);
        for (int i = 0; i < 16; i++) img[i] = iv;
        for (int i = 0; i < 9; i++)  wts[i] = wv;
        for (int i = 0; i < 4; i++)  exp_r[i] = rv;
    endtask

    // Entered just after a rising edge with the DUT in IDLE; the next edge is edge 0.
    task automatic run_pass(input string name, input logic hold);
        int n;
        logic strobe;
        n = 0;
        start = 1'b1;
        conv_num = img[0];
        for (int k = 0; k < 9; k++) weight_3x3[16*k +: 16] = wts[k];
        for (int e = 0; e <= 53; e++) begin
            @(posedge clk);
            #1;
            if (e < 15) conv_num = img[e+1];
            if (!hold) start = 1'b0;
            if (e <= 52) begin
                strobe = (e == 25 || e == 34 || e == 43 || e == 52);
                check($sformatf("%s_dv_e%0d", name, e), 16'(dout_valid), 16'(strobe));
                if (strobe) begin
                    check($sformatf("%s_res%0d", name, n), result, exp_r[n]);
                    n++;
                end
                if (e == 52) check($sformatf("%s_done_e52", name), 16'(done), 16'd0);
            end else begin
                check($sformatf("%s_done_e53", name), 16'(done), 16'd1);
                check($sformatf("%s_res_hold", name), result, exp_r[3]);
            end
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_done_pulse_end", name), 16'(done), 16'd0);
        end
    endtask

    initial begin
        int strobes;
        #2;
        check("rst_result", result, 16'h0000);
        check("rst_dv", 16'(dout_valid), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        set_all(16'h3C00, 16'h3C00, 16'h4880);
        run_pass("ones", 1'b0);

        for (int i = 0; i < 16; i++) img[i] = ramp[i];
        for (int i = 0; i < 9; i++)  wts[i] = (i == 4) ? 16'h3C00 : 16'h0000;
        exp_r[0] = 16'h4500; exp_r[1] = 16'h4600; exp_r[2] = 16'h4880; exp_r[3] = 16'h4900;
        run_pass("ramp", 1'b0);

`ifdef CONV_CONTROL_RELU_EN
        set_all(16'h3C00, 16'hBC00, 16'h0000);
`else
        set_all(16'h3C00, 16'hBC00, 16'hC880);
`endif
        run_pass("negw", 1'b0);

        set_all(16'h7BFF, 16'h7BFF, 16'h7BFF);
        run_pass("sat", 1'b0);

        // Abort a pass after the first window has been output.
        set_all(16'h3C00, 16'h3C00, 16'h4880);
        start = 1'b1;
        conv_num = 16'h3C00;
        for (int k = 0; k < 9; k++) weight_3x3[16*k +: 16] = 16'h3C00;
        for (int e = 0; e <= 29; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("abort_pre_result", result, 16'h4880);
        #2 rst_n = 1'b0;
        #1;
        check("abort_result", result, 16'h0000);
        check("abort_dv", 16'(dout_valid), 16'd0);
        check("abort_done", 16'(done), 16'd0);
        #3 rst_n = 1'b1;
        strobes = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (dout_valid) strobes++;
        end
        check("abort_no_strobes", 16'(strobes), 16'd0);
        check("abort_idle_done", 16'(done), 16'd0);

        for (int i = 0; i < 16; i++) img[i] = ramp[i];
        for (int i = 0; i < 9; i++)  wts[i] = (i == 4) ? 16'h3C00 : 16'h0000;
        exp_r[0] = 16'h4500; exp_r[1] = 16'h4600; exp_r[2] = 16'h4880; exp_r[3] = 16'h4900;
        run_pass("after_rst", 1'b0);

        // Start held through the pass: done must stay high with no new pass.
        set_all(16'h3C00, 16'h3C00, 16'h4880);
        run_pass("hold", 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_done_c%0d", c), 16'(done), 16'd1);
            check($sformatf("hold_dv_c%0d", c), 16'(dout_valid), 16'd0);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("hold_release_done", 16'(done), 16'd0);

        for (int i = 0; i < 16; i++) img[i] = ramp[i];
        for (int i = 0; i < 9; i++)  wts[i] = (i == 4) ? 16'h3C00 : 16'h0000;
        exp_r[0] = 16'h4500; exp_r[1] = 16'h4600; exp_r[2] = 16'h4880; exp_r[3] = 16'h4900;
        run_pass("restart", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
